op_window: RTL and testbench
============================

OP_WINDOW -- requirements
Module: op_window

Interface
REQ-001 Parameter IMG_WIDTH, default 640, image width in pixels (supported range 5..4091).
REQ-002 Parameter IMG_HEIGHT, default 480, image height in lines (supported range 5..4091).
REQ-003 Parameter DWIDTH, default 8, pixel width in bits; window width WW = DWIDTH*25.
REQ-004 XW = ceil(log2(IMG_WIDTH+5)) and YW = ceil(log2(IMG_HEIGHT+5)), each minimum 1.
REQ-005 Port clock  in  1  sole clock; all logic on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-007 Port start  in  1  single-cycle pulse that begins one frame sweep.
REQ-008 Port in_valid  in  1  pixel present on in_data.
REQ-009 Port in_data  in  DWIDTH  raster-order input pixel.
REQ-010 Port in_ready  out  1  block accepts in_data this cycle.
REQ-011 Port out_valid  out  1  window, x and y are valid this cycle.
REQ-012 Port window  out  WW  5x5 window; byte k = window[k*DWIDTH +: DWIDTH].
REQ-013 Port x  out  XW  sweep column of the newest window tap.
REQ-014 Port y  out  YW  sweep row of the newest window tap.
REQ-015 Port frame_done  out  1  single-cycle pulse after the last window of a frame.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN; start in IDLE moves to RUN and clears the sweep counters cx=0, cy=0.
REQ-017 start received in RUN SHALL be ignored.
REQ-018 The sweep SHALL cover cx 0..IMG_WIDTH+3 (inner) and cy 0..IMG_HEIGHT+3 (outer), for (IMG_WIDTH+4)*(IMG_HEIGHT+4) positions per frame.
REQ-019 A position needs input iff cx<IMG_WIDTH and cy<IMG_HEIGHT.
REQ-020 in_ready SHALL be combinational: 1 iff state=RUN and the current position needs input.
REQ-021 An advance occurs when state=RUN and either the position needs input and in_valid=1, or the position needs no input.
REQ-022 On an advance, the new pixel SHALL be in_data if input is needed, else 0.
REQ-023 Without an advance, counters, line buffers and the window register SHALL hold.
REQ-024 Four line buffers of depth IMG_WIDTH SHALL store the last four image rows; they are read and written at column cx only on advances with cx<IMG_WIDTH.
REQ-025 Window byte r*5+c SHALL hold the pixel at image row cy-r, column cx-c (r,c in 0..4); byte 0 is the newest pixel.
REQ-026 Any window byte whose row is outside 0..IMG_HEIGHT-1 or whose column is outside 0..IMG_WIDTH-1 SHALL output 0, regardless of stale line-buffer contents.
REQ-027 out_valid SHALL be registered and pulse exactly one cycle after each advance, with window, x=cx and y=cy of that advance; latency 1 cycle.
REQ-028 When out_valid=0, window, x and y SHALL hold their last values.
REQ-029 The advance at cx=IMG_WIDTH+3 SHALL wrap cx to 0 and increment cy.
REQ-030 The advance at cx=IMG_WIDTH+3, cy=IMG_HEIGHT+3 SHALL return the FSM to IDLE; frame_done SHALL pulse in the same cycle as that position's out_valid.
REQ-031 There SHALL be no output backpressure; the downstream stage accepts every out_valid.

Reset
REQ-032 With reset=0 at a clock edge: state=IDLE, cx=cy=0, out_valid=0, frame_done=0, window=0, x=0, y=0; in_ready=0 in the following cycle.
REQ-033 Line-buffer memory SHALL NOT require clearing; REQ-026 masking hides prior contents.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; no further out_valid until the next start.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pixel(r,c)=r*8+c+1)
REQ-035 Reset low for 2 cycles -> all outputs 0, in_ready=0, IDLE.
REQ-036 start, in_valid held 1 -> exactly 48 pixels accepted, 120 out_valid pulses, one frame_done coincident with x=11,y=9, then in_ready=0.
REQ-037 First output -> x=0, y=0, byte0=1, bytes 1..24=0; at x=4,y=4 -> byte0=37, byte24=1, byte12=19.
REQ-038 in_valid low for 5 cycles at cx=3,cy=2 -> no out_valid during the stall, x/y hold, resumed output sequence identical to the unstalled run.
REQ-039 Padding position x=11, y=2 -> out_valid without in_valid; only bytes r*5+4 (r=0..2) nonzero, byte4=pixel(2,7)=24.
REQ-040 Reset mid-frame at cy=3, then start -> sweep restarts at x=0,y=0; first window equals REQ-037 (no stale rows visible).

Source files
------------

// File: rtl/op_window.sv
// rtl/op_window.sv - 5x5 sliding window generator over a raster frame with zero-padded borders
module op_window #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DWIDTH     = 8,
    localparam int WW        = DWIDTH * 25,
    localparam int XW_RAW    = $clog2(IMG_WIDTH + 5),
    localparam int YW_RAW    = $clog2(IMG_HEIGHT + 5),
    localparam int XW        = (XW_RAW < 1) ? 1 : XW_RAW,
    localparam int YW        = (YW_RAW < 1) ? 1 : YW_RAW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WW-1:0]     window,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              frame_done
);

    localparam int AW_RAW = $clog2(IMG_WIDTH);
    localparam int AW     = (AW_RAW < 1) ? 1 : AW_RAW;

    localparam logic [XW-1:0] X_IMG  = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH + 3);
    localparam logic [YW-1:0] Y_IMG  = YW'(IMG_HEIGHT);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT + 3);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     cx;
    logic [YW-1:0]     cy;
    logic              col_in;
    logic              row_in;
    logic              need_in;
    logic              last_col;
    logic              last_pos;
    logic              advance;
    logic [DWIDTH-1:0] new_pix;
    logic [AW-1:0]     lb_addr;
    logic [4:1]        row_ok;
    logic [DWIDTH-1:0] col_pix [5];

    // Line buffer k holds image row cy-1-k; no reset, stale data is masked on read
    logic [DWIDTH-1:0] lb [4][IMG_WIDTH];

    assign col_in   = (cx < X_IMG);
    assign row_in   = (cy < Y_IMG);
    assign need_in  = col_in && row_in;
    assign last_col = (cx == X_LAST);
    assign last_pos = last_col && (cy == Y_LAST);
    assign new_pix  = need_in ? in_data : '0;
    assign lb_addr  = cx[AW-1:0];

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start launches a sweep, the final padded position ends it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (advance && last_pos) state_nxt = IDLE;
        endcase
    end

    // FSM outputs: padding positions advance on their own, image positions wait for a pixel
    always_comb begin
        in_ready = 1'b0;
        advance  = 1'b0;
        if (state == RUN) begin
            in_ready = need_in;
            advance  = need_in ? in_valid : 1'b1;
        end
    end

    // Sweep counters: raster order over the image plus four padding columns and rows
    always_ff @(posedge clock) begin
        if (!reset) begin
            cx <= '0;
            cy <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                cx <= '0;
                cy <= '0;
            end
        end else if (advance) begin
            if (last_col) begin
                cx <= '0;
                cy <= last_pos ? '0 : cy + YW'(1);
            end else begin
                cx <= cx + XW'(1);
            end
        end
    end

    // New window column: newest pixel plus four buffered rows, rows outside the image forced to zero
    always_comb begin
        for (int r = 1; r < 5; r++) begin
            row_ok[r] = (cy >= YW'(r)) && ((cy - YW'(r)) < Y_IMG);
        end
        col_pix[0] = new_pix;
        for (int r = 1; r < 5; r++) begin
            col_pix[r] = (col_in && row_ok[r]) ? lb[r-1][lb_addr] : '0;
        end
    end

    // Line buffers shift one row deeper at the current column
    always_ff @(posedge clock) begin
        if (advance && col_in) begin
            lb[0][lb_addr] <= new_pix;
            for (int k = 1; k < 4; k++) begin
                lb[k][lb_addr] <= lb[k-1][lb_addr];
            end
        end
    end

    // Window shifts one column per advance; padding columns flush old rows at each wrap
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            window     <= '0;
            x          <= '0;
            y          <= '0;
        end else begin
            out_valid  <= advance;
            frame_done <= advance && last_pos;
            if (advance) begin
                x <= cx;
                y <= cy;
                for (int r = 0; r < 5; r++) begin
                    window[(r*5)*DWIDTH +: DWIDTH] <= col_pix[r];
                    for (int c = 1; c < 5; c++) begin
                        window[(r*5+c)*DWIDTH +: DWIDTH] <= window[(r*5+c-1)*DWIDTH +: DWIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_op_window.sv
// tb/tb_op_window.sv - directed and table-driven checks for op_window on an 8x6 image
module tb_op_window;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int WW = DW * 25;
    localparam int NX = W + 4;
    localparam int NP = (W + 4) * (H + 4);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [WW-1:0] window;
    logic [3:0]    x;
    logic [3:0]    y;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] cap [NP];

    typedef struct {
        int px;
        int py;
        int bidx;
        int exp;
    } vec_t;

    vec_t vecs [12];

    always #5 clock = ~clock;

    op_window #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DWIDTH    (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .window    (window),
        .x         (x),
        .y         (y),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference window: byte r*5+c is pixel(py-r, px-c), zero outside the image
    function automatic logic [WW-1:0] model_win(input int px, input int py, input int off);
        logic [WW-1:0] w;
        int row;
        int col;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                row = py - r;
                col = px - c;
                if (row >= 0 && row < H && col >= 0 && col < W)
                    w[(r*5+c)*DW +: DW] = 8'(row * W + col + 1 + off);
            end
        end
        return w;
    endfunction

    // One frame sweep with in_valid high except an optional 5-cycle stall; optional reset abort
    task automatic run_frame(input int stall_acc, input int abort_acc, input int off, input string tag);
        int acc = 0;
        int outs = 0;
        int fd = 0;
        int cyc = 0;
        int hold = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit done = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'(off + 1);
        @(posedge clock); #1;
        start = 1'b0;
        while (!done && cyc < 3000) begin
            if (hold > 0) begin
                chk({tag, " stall out_valid"}, out_valid, 0);
                chk({tag, " stall x hold"}, x, 2);
                chk({tag, " stall y hold"}, y, 2);
                hold--;
            end
            if (out_valid) begin
                if (outs < NP) begin
                    chk({tag, " x"}, x, outs % NX);
                    chk({tag, " y"}, y, outs / NX);
                    chk_w({tag, " window"}, window, model_win(outs % NX, outs / NX, off));
                    cap[outs] = window;
                end
                outs++;
            end
            if (frame_done) begin
                fd++;
                chk({tag, " frame_done x"}, x, 11);
                chk({tag, " frame_done y"}, y, 9);
            end
            if (fd > 0) begin
                done = 1'b1;
            end else begin
                if (abort_acc >= 0 && acc == abort_acc && in_ready) begin
                    reset = 1'b0;
                    @(posedge clock); #1;
                    reset = 1'b1;
                    return;
                end
                if (stall_acc >= 0 && !stalled && acc == stall_acc && in_ready) begin
                    stalled    = 1'b1;
                    stall_left = 5;
                    hold       = 5;
                end
                if (stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                end else begin
                    in_valid = 1'b1;
                end
                start   = (stall_acc >= 0 && acc == 30);
                in_data = 8'(acc + 1 + off);
                if (in_ready && in_valid) acc++;
                @(posedge clock); #1;
                cyc++;
            end
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL %s timeout: got no frame_done within %0d cycles", tag, cyc);
        end
        chk({tag, " accepted"}, acc, W * H);
        chk({tag, " out count"}, outs, NP);
        chk({tag, " frame_done count"}, fd, 1);
        chk({tag, " in_ready after"}, in_ready, 0);
        @(posedge clock); #1;
        chk({tag, " in_ready idle"}, in_ready, 0);
        chk({tag, " out_valid idle"}, out_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 1};
        vecs[1]  = '{0, 0, 1, 0};
        vecs[2]  = '{0, 0, 24, 0};
        vecs[3]  = '{4, 4, 0, 37};
        vecs[4]  = '{4, 4, 24, 1};
        vecs[5]  = '{4, 4, 12, 19};
        vecs[6]  = '{11, 2, 4, 24};
        vecs[7]  = '{11, 2, 9, 16};
        vecs[8]  = '{11, 2, 14, 8};
        vecs[9]  = '{11, 2, 0, 0};
        vecs[10] = '{11, 2, 19, 0};
        vecs[11] = '{11, 9, 24, 48};

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset frame_done", frame_done, 0);
        chk_w("reset window", window, '0);
        chk("reset x", x, 0);
        chk("reset y", y, 0);
        chk("reset in_ready", in_ready, 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        chk("idle in_ready", in_ready, 0);
        chk("idle out_valid", out_valid, 0);

        run_frame(-1, -1, 0, "clean");
        for (int i = 0; i < 12; i++) begin
            logic [WW-1:0] w;
            w = cap[vecs[i].py * NX + vecs[i].px];
            chk($sformatf("table%0d x%0d y%0d byte%0d", i, vecs[i].px, vecs[i].py, vecs[i].bidx),
                w[vecs[i].bidx*DW +: DW], vecs[i].exp);
        end

        run_frame(19, -1, 0, "stall");

        run_frame(-1, 24, 100, "abort");
        chk("abort out_valid", out_valid, 0);
        chk("abort frame_done", frame_done, 0);
        chk_w("abort window", window, '0);
        chk("abort x", x, 0);
        chk("abort y", y, 0);
        chk("abort in_ready", in_ready, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("post-abort out_valid", out_valid, 0);
            chk("post-abort in_ready", in_ready, 0);
        end

        run_frame(-1, -1, 0, "restart");
        begin
            logic [WW-1:0] w0;
            w0 = cap[0];
            chk("restart first byte0", w0[DW-1:0], 1);
            chk_w("restart first upper bytes", w0 >> DW, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
